// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: display code constants, active-low segment patterns
// (bit6 = g .. bit0 = a) and small code-classification helpers.
package seg_pkg;

    localparam logic [3:0] CODE_UP    = 4'd10;
    localparam logic [3:0] CODE_DOWN  = 4'd11;
    localparam logic [3:0] CODE_DASH  = 4'd12;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_UP    = 7'b101_1100;
    localparam logic [6:0] SEG_DOWN  = 7'b110_0011;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_UP:    seg = SEG_UP;
            CODE_DOWN:  seg = SEG_DOWN;
            CODE_DASH:  seg = SEG_DASH;
            CODE_BLANK: seg = SEG_BLANK;
            default:    seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // A code that lets a lower zero be treated as leading: zero itself or any blank code.
    function automatic logic code_is_leading(input logic [3:0] code);
        return (code == 4'd0) || (code >= 4'd13);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Signal bundle between a display controller (master) and the scan driver (slave).
interface seg_scan_driver_if;
    logic [15:0] code_in;
    logic        load;
    logic [1:0]  dim;
    logic [3:0]  digit;
    logic [6:0]  display;
    logic        frame_done;

    modport master (output code_in, load, dim, input digit, display, frame_done);
    modport slave  (input code_in, load, dim, output digit, display, frame_done);
endinterface

// File: rtl/seg_decode.sv
// Combinational 4-bit display code to active-low 7-segment decoder.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);
    assign o_seg = seg_pattern(i_code);
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with frame-synchronous code update and dimming.
// Define SEG_LZ_SUPPRESS_EN to blank leading zeros on digits 3..1.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIV_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] code_in,
    input  logic        load,
    input  logic [1:0]  dim,
    output logic [3:0]  DIGIT,
    output logic [6:0]  DISPLAY,
    output logic        frame_done
);
    localparam logic [DIV_W-1:0] CNT_MAX = '1;
    localparam logic [DIV_W-1:0] CNT_ONE = 1;

    logic [DIV_W-1:0] r_cnt;
    logic [1:0]       r_slot;
    logic [15:0]      r_shadow;
    logic [15:0]      r_pending;
    logic             r_pending_valid;
    logic [3:0]       r_digit;
    logic [6:0]       r_display;

    logic             w_frame_done;
    logic [2:0]       w_weight;
    logic [DIV_W:0]   w_span;
    logic [DIV_W:0]   w_limit;
    logic             w_on;
    logic [3:0]       w_code;
    logic [6:0]       w_seg;
    logic             w_suppress;

    assign w_frame_done = (r_slot == 2'd3) && (r_cnt == CNT_MAX);

    // On-window is cnt = 1 .. (4-dim)*2^(DIV_W-2)-1; cnt = 0 is always dark to avoid ghosting.
    assign w_weight = 3'd4 - {1'b0, dim};
    assign w_span   = {{(DIV_W-2){1'b0}}, w_weight} << (DIV_W-2);
    assign w_limit  = w_span - {{DIV_W{1'b0}}, 1'b1};
    assign w_on     = (r_cnt != '0) && ({1'b0, r_cnt} <= w_limit);

    assign w_code = r_shadow[{r_slot, 2'b00} +: 4];

    seg_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

`ifdef SEG_LZ_SUPPRESS_EN
    logic [3:0] w_lz;
    always_comb begin
        w_lz    = 4'b0000;
        w_lz[3] = (r_shadow[15:12] == 4'd0);
        w_lz[2] = (r_shadow[11:8] == 4'd0) && code_is_leading(r_shadow[15:12]);
        w_lz[1] = (r_shadow[7:4] == 4'd0) && code_is_leading(r_shadow[11:8])
                  && code_is_leading(r_shadow[15:12]);
    end
    assign w_suppress = w_lz[r_slot];
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_slot <= 2'd0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_MAX) begin
                r_slot <= r_slot + 2'd1;
            end
        end
    end

    // Shadow only changes at a frame boundary so a frame never shows mixed content.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow        <= 16'hFFFF;
            r_pending       <= 16'h0000;
            r_pending_valid <= 1'b0;
        end else if (load && w_frame_done) begin
            r_shadow        <= code_in;
            r_pending       <= code_in;
            r_pending_valid <= 1'b0;
        end else if (load) begin
            r_pending       <= code_in;
            r_pending_valid <= 1'b1;
        end else if (w_frame_done && r_pending_valid) begin
            r_shadow        <= r_pending;
            r_pending_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_digit   <= 4'b1111;
            r_display <= SEG_BLANK;
        end else if (w_on) begin
            r_digit   <= 4'b1111 ^ (4'b0001 << r_slot);
            r_display <= w_suppress ? SEG_BLANK : w_seg;
        end else begin
            r_digit   <= 4'b1111;
            r_display <= SEG_BLANK;
        end
    end

    assign DIGIT      = r_digit;
    assign DISPLAY    = r_display;
    assign frame_done = w_frame_done;

endmodule
